latch_rf_write_arbiter: RTL

LATCH_RF_WRITE_ARBITER -- requirements
Module: latch_rf_write_arbiter

---
 rtl/latch_rf_write_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/latch_rf_write_arbiter.sv
// Round-robin write arbiter for a D-latch register file.
// Each write takes a 4-cycle slot: IDLE (grant) -> SETUP (data on WD)
// -> CAPTURE (one LE pulse) -> HOLD (latch closed, ACK) -> IDLE.
// All outputs come straight from flops so LE/nLE are glitch-free.
module latch_rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int W    = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*AW-1:0]   ADDR,
  input  logic [NREQ*W-1:0]    DATA,
  output logic [NREQ-1:0]      ACK,
  output logic [W-1:0]         WD,
  output logic [NREG-1:0]      LE,
  output logic [NREG-1:0]      nLE,
  output logic                 BUSY
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] NREQ_V = (IW+1)'(NREQ);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [1:0]        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     gnt;
  logic [AW-1:0]     cap_addr;

  logic [2*NREQ-1:0] rot;
  logic [IW:0]       off;
  logic              found;
  logic [IW:0]       sum;
  logic [IW:0]       nxt;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     ptr_nxt;
  logic [AW-1:0]     sel_addr;
  logic [W-1:0]      sel_data;
  logic [NREG-1:0]   le_dec;
  logic [NREQ-1:0]   ack_dec;

  // Round-robin pick: rotate requests so the search starts at ptr, take the
  // first set bit, then map the offset back to an absolute requester index.
  always_comb begin
    rot   = {REQ, REQ} >> ptr;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        off   = (IW+1)'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= NREQ_V) sum = sum - NREQ_V;
    pick = sum[IW-1:0];
    nxt  = {1'b0, pick} + (IW+1)'(1);
    if (nxt >= NREQ_V) nxt = '0;
    ptr_nxt = nxt[IW-1:0];
  end

  // Mux the winning requester's address and data slices.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == IW'(k)) begin
        sel_addr = ADDR[k*AW +: AW];
        sel_data = DATA[k*W +: W];
      end
    end
  end

  // One-hot decodes for the latch enable and the completion pulse.
  always_comb begin
    le_dec           = '0;
    le_dec[cap_addr] = 1'b1;
    ack_dec          = '0;
    ack_dec[gnt]     = 1'b1;
  end

  // Captured target register; only meaningful once granted, so no reset.
  always_ff @(posedge CLK) begin
    if (state == IDLE && |REQ) cap_addr <= sel_addr;
  end

  // Slot sequencer; every output is loaded here so nothing is decoded
  // combinationally on the way to the latches.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      WD    <= '0;
      LE    <= '0;
      nLE   <= '1;
      ACK   <= '0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|REQ) begin
            state <= SETUP;
            gnt   <= pick;
            ptr   <= ptr_nxt;
            WD    <= sel_data;
            BUSY  <= 1'b1;
          end
        end
        SETUP: begin
          state <= CAPTURE;
          LE    <= le_dec;
          nLE   <= ~le_dec;
        end
        CAPTURE: begin
          state <= HOLD;
          LE    <= '0;
          nLE   <= '1;
          ACK   <= ack_dec;
        end
        default: begin
          state <= IDLE;
          LE    <= '0;
          nLE   <= '1;
          ACK   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
